gcd_engine: RTL and testbench

//   Iterative subtraction-based Euclid GCD unit; the relprime datapath instantiates it as its gcd step.

---
 rtl/gcd_engine.sv | 118 +++++++++++
 tb/tb_gcd_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// Iterative subtraction-based Euclid GCD unit with a one-cycle done pulse and coprime flag.
// Optional CALC-cycle counter enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_engine #(
  parameter int unsigned W     = 16
`ifdef GCD_CYCLE_COUNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     gcd_out,
  output logic             coprime
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [W-1:0] a_q, b_q, a_next, b_next;
  logic [W-1:0] result;
  logic         fin;

`ifdef GCD_CYCLE_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] cnt_q, cnt_next;
`endif

  // Next-state and datapath step: one Euclid subtraction per CALC edge.
  always_comb begin
    state_next = state;
    a_next     = a_q;
    b_next     = b_q;
    result     = '0;
    fin        = 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_next   = cnt_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          a_next     = a_in;
          b_next     = b_in;
          state_next = S_CALC;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_next   = '0;
`endif
        end
      end
      S_CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`endif
        if (a_q == '0) begin
          result     = b_q;
          fin        = 1'b1;
          state_next = S_DONE;
        end else if (b_q == '0) begin
          result     = a_q;
          fin        = 1'b1;
          state_next = S_DONE;
        end else if (a_q > b_q) begin
          a_next = a_q - b_q;
        end else begin
          b_next = b_q - a_q;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, operands and registered outputs; reset aborts any operation.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      gcd_out     <= '0;
      coprime     <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q       <= '0;
      cycle_count <= '0;
`endif
    end else begin
      state <= state_next;
      a_q   <= a_next;
      b_q   <= b_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state_next == S_DONE);
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q <= cnt_next;
`endif
      if (fin) begin
        gcd_out     <= result;
        coprime     <= (result == W'(1));
`ifdef GCD_CYCLE_COUNT_EN
        cycle_count <= cnt_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: expectations queued at start, compared on each done pulse.
module tb_gcd_engine;

  localparam int unsigned W = 16;
`ifdef GCD_CYCLE_COUNT_EN
  localparam int unsigned CNT_W = 32;
`endif

  typedef struct {
    logic [W-1:0] g;
    logic         cp;
    int unsigned  cnt;
  } exp_t;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, coprime;
  logic [W-1:0] gcd_out;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_count;
`endif

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 CLK = ~CLK;

  gcd_engine #(
    .W(W)
`ifdef GCD_CYCLE_COUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out),
    .coprime (coprime)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model_gcd(input logic [W-1:0] a0, input logic [W-1:0] b0);
    logic [W-1:0] x = a0;
    logic [W-1:0] y = b0;
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of CALC edges for the subtraction algorithm, terminating edge included.
  function automatic int unsigned model_cnt(input logic [W-1:0] a0, input logic [W-1:0] b0);
    logic [W-1:0] x = a0;
    logic [W-1:0] y = b0;
    int unsigned  n = 0;
    for (int i = 0; i < 70000; i++) begin
      n++;
      if (x == '0 || y == '0) break;
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return n;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("gcd_out", 32'(gcd_out), 32'(e.g));
        check_eq("coprime", 32'(coprime), 32'(e.cp));
`ifdef GCD_CYCLE_COUNT_EN
        check_eq("cycle_count", cycle_count, e.cnt);
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eg, input logic ecp,
                        input int unsigned ecnt, input bit mid_start);
    bit seen;
    exp_q.push_back('{g: eg, cp: ecp, cnt: ecnt});
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge CLK);
    #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    if (mid_start) begin
      repeat (5) @(posedge CLK);
      #1;
      start = 1'b1;
      a_in  = W'(3);
      b_in  = W'(9);
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 70000 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    @(posedge CLK);
    #1;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_after_done", 32'(busy), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq("gcd_held", 32'(gcd_out), 32'(eg));
  endtask

  initial begin
    logic [W-1:0] ra, rb, rg;

    // Reset held with start asserted: unit must stay idle with cleared outputs.
    reset = 1'b1;
    start = 1'b1;
    a_in  = W'(12);
    b_in  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_gcd", 32'(gcd_out), 32'd0);
    check_eq("rst_coprime", 32'(coprime), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_eq("rst_cycle_count", cycle_count, 32'd0);
`endif
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("idle_after_rst", 32'(busy), 32'd0);

    run_op(W'(12), W'(18), W'(6), 1'b0, 4, 1'b0);
    run_op(W'(36432), W'(5), W'(1), 1'b1, model_cnt(W'(36432), W'(5)), 1'b0);
    run_op(W'(36432), W'(2), W'(2), 1'b0, 18217, 1'b1);
    run_op(W'(0), W'(0), W'(0), 1'b0, 1, 1'b0);
    run_op(W'(7), W'(0), W'(7), 1'b0, 1, 1'b0);
    run_op(W'(0), W'(9), W'(9), 1'b0, 1, 1'b0);
    run_op(W'(5), W'(5), W'(5), 1'b0, 2, 1'b0);
    run_op(W'(1), W'(10), W'(1), 1'b1, model_cnt(W'(1), W'(10)), 1'b0);

    // Abort mid-CALC with reset: no done, outputs cleared, then a clean operation.
    start = 1'b1;
    a_in  = W'(40000);
    b_in  = W'(3);
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_gcd", 32'(gcd_out), 32'd0);
    check_eq("abort_coprime", 32'(coprime), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_eq("abort_cycle_count", cycle_count, 32'd0);
`endif
    repeat (3) @(posedge CLK);
    #1;
    check_eq("abort_stays_idle", 32'(busy), 32'd0);
    run_op(W'(9), W'(6), W'(3), 1'b0, 4, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom_range(1, 200));
      rb = W'($urandom_range(0, 200));
      rg = model_gcd(ra, rb);
      run_op(ra, rb, rg, (rg == W'(1)), model_cnt(ra, rb), 1'b0);
    end

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
